// File: rtl/game_irq_scheduler.sv
// Game interrupt scheduler: latches collision/tick/button/switch events as pending,
// picks the lowest-numbered unmasked one and runs the KCPSM6 interrupt/ack/EOI handshake.
//
// state   | meaning
// IDLE    | no interrupt outstanding, arbitrating pending & mask
// ASSERT  | interrupt driven high, waiting for interrupt_ack
// SERVICE | handler running, waiting for an EOI port write
module game_irq_scheduler #(
   parameter int unsigned TICK_CYCLES = 1000000,
   parameter logic [7:0]  MASK_PORT   = 8'h10,
   parameter logic [7:0]  CAUSE_PORT  = 8'h11,
   parameter logic [7:0]  EOI_PORT    = 8'h12,
   parameter logic [7:0]  MISS_PORT   = 8'h13,
   parameter logic [7:0]  PEND_PORT   = 8'h14
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       collision_detect,
   input  logic [3:0] db_btns,
   input  logic [7:0] db_sw,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       interrupt_ack,
   output logic       interrupt,
   output logic [7:0] rd_data,
   output logic       rd_hit
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   localparam logic [23:0] TICK_LAST = 24'(TICK_CYCLES - 1);

   state_t      state_q, state_d;
   logic        coll_prev_q, coll_prev_d;
   logic [3:0]  btns_prev_q, btns_prev_d;
   logic [7:0]  sw_prev_q, sw_prev_d;
   logic [23:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]  pending_q, pending_d;
   logic [7:0]  miss_cnt_q, miss_cnt_d;
   logic [3:0]  mask_q, mask_d;
   logic [3:0]  cause_q, cause_d;
   logic        interrupt_q, interrupt_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_hit_q, rd_hit_d;

   logic        tick;
   logic [3:0]  events;
   logic [3:0]  irq_req;
   logic [3:0]  sel_onehot;
   logic [3:0]  sel_clr;
   logic [3:0]  pend_kept;
   logic        miss_hit;
   logic        mask_wr;
   logic        eoi_wr;
   logic        miss_wr;
   logic [3:0]  unused_out_hi;

   assign unused_out_hi = out_port[7:4];

   assign mask_wr = write_strobe && (port_id == MASK_PORT);
   assign eoi_wr  = write_strobe && (port_id == EOI_PORT);
   assign miss_wr = write_strobe && (port_id == MISS_PORT);

   // Event detection against last cycle's sampled inputs
   always_comb begin
      coll_prev_d = collision_detect;
      btns_prev_d = db_btns;
      sw_prev_d   = db_sw;
      tick        = (tick_cnt_q == TICK_LAST);
      events[0]   = collision_detect & ~coll_prev_q;
      events[1]   = tick;
      events[2]   = |(db_btns & ~btns_prev_q);
      events[3]   = |(db_sw ^ sw_prev_q);
   end

   always_comb begin
      tick_cnt_d = tick ? 24'd0 : tick_cnt_q + 24'd1;
   end

   always_comb begin
      irq_req    = pending_q & mask_q;
      sel_onehot = irq_req & (~irq_req + 4'd1);
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (|irq_req)     state_d = ST_ASSERT;
         ST_ASSERT:  if (interrupt_ack) state_d = ST_SERVICE;
         ST_SERVICE: if (eoi_wr)        state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs (registered cause/interrupt, selection clear)
   always_comb begin
      cause_d     = cause_q;
      interrupt_d = interrupt_q;
      sel_clr     = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            if (|irq_req) begin
               cause_d     = sel_onehot;
               interrupt_d = 1'b1;
               sel_clr     = sel_onehot;
            end
         end
         ST_ASSERT: begin
            interrupt_d = ~interrupt_ack;
         end
         ST_SERVICE: begin
            interrupt_d = 1'b0;
            if (eoi_wr) cause_d = 4'b0000;
         end
         default: begin
            cause_d     = 4'b0000;
            interrupt_d = 1'b0;
         end
      endcase
   end

   // A new event on the same bit as a selection re-arms it; a miss is an event
   // landing on a bit that stays pending.
   always_comb begin
      pend_kept = pending_q & ~sel_clr;
      pending_d = pend_kept | events;
      miss_hit  = |(events & pend_kept);
      miss_cnt_d = miss_cnt_q;
      if (miss_wr) begin
         miss_cnt_d = 8'h00;
      end else if (miss_hit && (miss_cnt_q != 8'hFF)) begin
         miss_cnt_d = miss_cnt_q + 8'd1;
      end
      mask_d = mask_wr ? out_port[3:0] : mask_q;
   end

   always_comb begin
      rd_data_d = 8'h00;
      rd_hit_d  = 1'b1;
      case (port_id)
         MASK_PORT:  rd_data_d = {4'b0000, mask_q};
         CAUSE_PORT: rd_data_d = {4'b0000, cause_q};
         MISS_PORT:  rd_data_d = miss_cnt_q;
         PEND_PORT:  rd_data_d = {4'b0000, pending_q};
         default:    rd_hit_d  = 1'b0;
      endcase
   end

   // Previous-value registers track inputs through reset so nothing fires on release
   always_ff @(posedge clk) begin
      coll_prev_q <= coll_prev_d;
      btns_prev_q <= btns_prev_d;
      sw_prev_q   <= sw_prev_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q  <= 24'd0;
         pending_q   <= 4'b0000;
         miss_cnt_q  <= 8'h00;
         mask_q      <= 4'b0011;
         cause_q     <= 4'b0000;
         interrupt_q <= 1'b0;
         rd_data_q   <= 8'h00;
         rd_hit_q    <= 1'b0;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         pending_q   <= pending_d;
         miss_cnt_q  <= miss_cnt_d;
         mask_q      <= mask_d;
         cause_q     <= cause_d;
         interrupt_q <= interrupt_d;
         rd_data_q   <= rd_data_d;
         rd_hit_q    <= rd_hit_d;
      end
   end

   assign interrupt = interrupt_q;
   assign rd_data   = rd_data_q;
   assign rd_hit    = rd_hit_q;

endmodule

// File: tb/tb_game_irq_scheduler.sv
// Directed bench for game_irq_scheduler with an 8-cycle tick; inputs change and
// outputs are sampled on the falling edge.
module tb_game_irq_scheduler;

   localparam logic [7:0] P_MASK  = 8'h10;
   localparam logic [7:0] P_CAUSE = 8'h11;
   localparam logic [7:0] P_EOI   = 8'h12;
   localparam logic [7:0] P_MISS  = 8'h13;
   localparam logic [7:0] P_PEND  = 8'h14;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       collision_detect = 1'b0;
   logic [3:0] db_btns = 4'h0;
   logic [7:0] db_sw = 8'h00;
   logic [7:0] port_id = 8'h00;
   logic [7:0] out_port = 8'h00;
   logic       write_strobe = 1'b0;
   logic       interrupt_ack = 1'b0;
   logic       interrupt;
   logic [7:0] rd_data;
   logic       rd_hit;

   int checks_cnt = 0;
   int errors_cnt = 0;

   game_irq_scheduler #(.TICK_CYCLES(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .collision_detect (collision_detect),
      .db_btns          (db_btns),
      .db_sw            (db_sw),
      .port_id          (port_id),
      .out_port         (out_port),
      .write_strobe     (write_strobe),
      .interrupt_ack    (interrupt_ack),
      .interrupt        (interrupt),
      .rd_data          (rd_data),
      .rd_hit           (rd_hit)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to the next falling edge and drop single-cycle bus pulses
   task automatic next_cyc();
      @(negedge clk);
      write_strobe  = 1'b0;
      interrupt_ack = 1'b0;
      out_port      = 8'h00;
   endtask

   // Leaves the bench in the first cycle after reset release (tick counter = 0)
   task automatic reset_dut();
      rst = 1'b1;
      collision_detect = 1'b0;
      db_btns = 4'h0;
      db_sw = 8'h00;
      port_id = 8'h00;
      next_cyc();
      next_cyc();
      rst = 1'b0;
   endtask

   task automatic bus_write(input logic [7:0] port, input logic [7:0] data);
      port_id      = port;
      out_port     = data;
      write_strobe = 1'b1;
   endtask

   logic exp_int;

   initial begin
      // Reset values and read mux
      reset_dut();
      check_val("rst_irq", interrupt, 0);
      check_val("rst_rd_data", rd_data, 8'h00);
      check_val("rst_rd_hit", rd_hit, 0);
      port_id = P_MASK;
      next_cyc();
      check_val("mask_default", rd_data, 8'h03);
      check_val("mask_hit", rd_hit, 1);
      port_id = 8'h20;
      next_cyc();
      check_val("unmapped_data", rd_data, 8'h00);
      check_val("unmapped_hit", rd_hit, 0);
      port_id = P_PEND;
      next_cyc();
      check_val("rst_pend", rd_data, 8'h00);
      port_id = P_MISS;
      next_cyc();
      check_val("rst_miss", rd_data, 8'h00);
      port_id = P_CAUSE;
      next_cyc();
      check_val("rst_cause", rd_data, 8'h00);

      // Periodic tick: ack one cycle after interrupt, EOI two cycles after ack
      reset_dut();
      for (int t = 0; t < 28; t++) begin
         exp_int = (t >= 9) && ((t % 8 == 1) || (t % 8 == 2));
         check_val("tick_irq", interrupt, exp_int);
         if (t >= 10 && t % 8 == 2) check_val("tick_cause", rd_data, 8'h02);
         port_id = P_CAUSE;
         if (t >= 10 && t % 8 == 2) interrupt_ack = 1'b1;
         if (t >= 12 && t % 8 == 4) bus_write(P_EOI, 8'h00);
         next_cyc();
      end
      port_id = P_MISS;
      next_cyc();
      check_val("tick_miss", rd_data, 8'h00);

      // Simultaneous collision and button with everything unmasked
      reset_dut();
      bus_write(P_MASK, 8'h0F);
      next_cyc();
      port_id = 8'h00;
      collision_detect = 1'b1;
      db_btns = 4'b0001;
      next_cyc();
      next_cyc();
      check_val("prio_irq1", interrupt, 1);
      interrupt_ack = 1'b1;
      port_id = P_PEND;
      next_cyc();
      check_val("prio_ack", interrupt, 0);
      check_val("prio_pend1", rd_data, 8'h04);
      port_id = P_CAUSE;
      next_cyc();
      check_val("prio_cause1", rd_data, 8'h01);
      bus_write(P_EOI, 8'h00);
      next_cyc();
      check_val("prio_gap", interrupt, 0);
      next_cyc();
      check_val("prio_irq2", interrupt, 1);
      port_id = P_PEND;
      next_cyc();
      check_val("prio_pend2", rd_data, 8'h00);
      port_id = P_CAUSE;
      next_cyc();
      check_val("prio_cause2", rd_data, 8'h04);

      // Masked switch event, then unmask it
      reset_dut();
      bus_write(P_MASK, 8'h01);
      next_cyc();
      port_id = 8'h00;
      db_sw = 8'h01;
      next_cyc();
      check_val("sw_masked_irq0", interrupt, 0);
      port_id = P_PEND;
      next_cyc();
      check_val("sw_masked_irq1", interrupt, 0);
      check_val("sw_pend", rd_data, 8'h08);
      bus_write(P_MASK, 8'h08);
      next_cyc();
      check_val("sw_unmask_wait", interrupt, 0);
      next_cyc();
      check_val("sw_unmask_irq", interrupt, 1);
      port_id = P_CAUSE;
      next_cyc();
      check_val("sw_cause", rd_data, 8'h08);

      // Miss counter saturation while parked in SERVICE
      reset_dut();
      collision_detect = 1'b1;
      next_cyc();
      collision_detect = 1'b0;
      next_cyc();
      check_val("miss_irq", interrupt, 1);
      interrupt_ack = 1'b1;
      next_cyc();
      for (int i = 0; i < 300; i++) begin
         collision_detect = 1'b1;
         next_cyc();
         collision_detect = 1'b0;
         next_cyc();
      end
      check_val("miss_service_irq", interrupt, 0);
      port_id = P_MISS;
      next_cyc();
      check_val("miss_sat", rd_data, 8'hFF);
      bus_write(P_MISS, 8'h00);
      next_cyc();
      next_cyc();
      check_val("miss_clear", rd_data, 8'h00);

      // Reset while in ASSERT; EOI in ASSERT and ack in IDLE are ignored
      reset_dut();
      collision_detect = 1'b1;
      next_cyc();
      collision_detect = 1'b0;
      next_cyc();
      check_val("assert_irq", interrupt, 1);
      db_btns = 4'b0010;
      bus_write(P_EOI, 8'h00);
      next_cyc();
      check_val("eoi_in_assert", interrupt, 1);
      rst = 1'b1;
      next_cyc();
      check_val("midrst_irq", interrupt, 0);
      rst = 1'b0;
      port_id = P_CAUSE;
      next_cyc();
      check_val("midrst_cause", rd_data, 8'h00);
      check_val("midrst_hit", rd_hit, 1);
      port_id = P_PEND;
      next_cyc();
      check_val("midrst_pend", rd_data, 8'h00);
      interrupt_ack = 1'b1;
      next_cyc();
      collision_detect = 1'b1;
      next_cyc();
      collision_detect = 1'b0;
      next_cyc();
      check_val("idle_ack_irq", interrupt, 1);
      next_cyc();
      check_val("idle_ack_hold", interrupt, 1);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
